// File: rtl/moesi_snoop_arbiter_if.sv
// Request/snoop-bus bundle between the per-core MOESI controllers and the snoop arbiter.
// slave = arbiter side, master = requesters plus bus-completion source.
interface moesi_snoop_arbiter_if #(
   parameter  int NUM_CORES = 4,
   parameter  int ADDR_W    = 32,
   localparam int SRC_W     = $clog2(NUM_CORES)
);
   logic [NUM_CORES-1:0]        req_valid;
   logic [2*NUM_CORES-1:0]      req_op;
   logic [ADDR_W*NUM_CORES-1:0] req_addr;
   logic [NUM_CORES-1:0]        req_ready;
   logic                        bus_valid;
   logic [1:0]                  bus_op;
   logic [ADDR_W-1:0]           bus_addr;
   logic [SRC_W-1:0]            bus_src;
   logic                        bus_done;
   logic                        busy;
   logic                        timeout_err;

   modport slave (
      input  req_valid, req_op, req_addr, bus_done,
      output req_ready, bus_valid, bus_op, bus_addr, bus_src, busy, timeout_err
   );

   modport master (
      output req_valid, req_op, req_addr, bus_done,
      input  req_ready, bus_valid, bus_op, bus_addr, bus_src, busy, timeout_err
   );
endinterface

// File: rtl/moesi_snoop_arbiter.sv
// Round-robin snoop-bus arbiter: grants one coherence request at a time, broadcasts it,
// holds the bus until bus_done, and raises a sticky flag if the transaction hangs.
module moesi_snoop_arbiter #(
   parameter  int NUM_CORES = 4,
   parameter  int ADDR_W    = 32,
   parameter  int TIMEOUT   = 255,
   localparam int SRC_W     = $clog2(NUM_CORES)
) (
   input logic                  clk,
   input logic                  rst_n,
   moesi_snoop_arbiter_if.slave bus_if
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_e;

   localparam logic [15:0] TMO = 16'(TIMEOUT);

   state_e               state_q, state_d;
   logic [SRC_W-1:0]     ptr_q, ptr_d;
   logic [SRC_W-1:0]     src_q, src_d;
   logic [1:0]           op_q, op_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [NUM_CORES-1:0] rdy_q, rdy_d;
   logic [15:0]          cnt_q, cnt_d;
   logic                 err_q, err_d;

   logic                 gnt_found;
   logic [SRC_W-1:0]     gnt_idx;
   logic [1:0]           gnt_op;
   logic [ADDR_W-1:0]    gnt_addr;

   // Two passes instead of a rotate: first set bit at or above ptr, else first set bit overall.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
         if (!gnt_found && (SRC_W'(j) >= ptr_q) && bus_if.req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = SRC_W'(j);
         end
      end
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
         if (!gnt_found && bus_if.req_valid[j]) begin
            gnt_found = 1'b1;
            gnt_idx   = SRC_W'(j);
         end
      end
   end

   always_comb begin
      gnt_op   = '0;
      gnt_addr = '0;
      for (int unsigned j = 0; j < NUM_CORES; j++) begin
         if (SRC_W'(j) == gnt_idx) begin
            gnt_op   = bus_if.req_op[2*j +: 2];
            gnt_addr = bus_if.req_addr[ADDR_W*j +: ADDR_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      src_d   = src_q;
      op_d    = op_q;
      addr_d  = addr_q;
      rdy_d   = '0;
      cnt_d   = cnt_q;
      err_d   = err_q;

      unique case (state_q)
         S_IDLE: begin
            if (gnt_found) begin
               src_d   = gnt_idx;
               op_d    = gnt_op;
               addr_d  = gnt_addr;
               rdy_d   = NUM_CORES'(1) << gnt_idx;
               ptr_d   = (gnt_idx == SRC_W'(NUM_CORES-1)) ? '0 : gnt_idx + 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (bus_if.bus_done) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               // ISSUE counts as the first watchdog cycle so the limit lands at ISSUE+TIMEOUT.
               cnt_d   = 16'd1;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus_if.bus_done) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else if (cnt_q >= TMO) begin
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         src_q   <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         rdy_q   <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         src_q   <= src_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         rdy_q   <= rdy_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus_if.req_ready   = rdy_q;
   assign bus_if.bus_valid   = (state_q == S_ISSUE);
   assign bus_if.bus_op      = op_q;
   assign bus_if.bus_addr    = addr_q;
   assign bus_if.bus_src     = src_q;
   assign bus_if.busy        = (state_q != S_IDLE);
   assign bus_if.timeout_err = err_q;

endmodule

// File: tb/tb_moesi_snoop_arbiter.sv
// Directed bench for moesi_snoop_arbiter: expected grants are queued as requests are driven
// and popped when the broadcast strobe appears.
module tb_moesi_snoop_arbiter;

   typedef struct {
      logic [1:0]  src;
      logic [1:0]  op;
      logic [31:0] addr;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_fail;
   exp_t sb[$];
   exp_t last;

   moesi_snoop_arbiter_if #(.NUM_CORES(4), .ADDR_W(32)) bus_if ();

   moesi_snoop_arbiter #(
      .NUM_CORES(4),
      .ADDR_W   (32),
      .TIMEOUT  (8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus_if(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic set_req(input int c, input logic [1:0] op, input logic [31:0] addr);
      bus_if.req_valid[c]        = 1'b1;
      bus_if.req_op[2*c +: 2]    = op;
      bus_if.req_addr[32*c +: 32] = addr;
   endtask

   task automatic clr_req(input int c);
      bus_if.req_valid[c] = 1'b0;
   endtask

   task automatic push(input int c, input logic [1:0] op, input logic [31:0] addr);
      exp_t e;
      e.src  = 2'(c);
      e.op   = op;
      e.addr = addr;
      sb.push_back(e);
   endtask

   task automatic expect_grant(input string tag, input int exp_wait);
      exp_t       e;
      int         w;
      logic [3:0] rdy_exp;
      w = 0;
      do begin
         @(negedge clk);
         w++;
      end while (!bus_if.bus_valid && w < 20);
      chk({tag, "/valid"}, bus_if.bus_valid, 1'b1);
      chk({tag, "/latency"}, w, exp_wait);
      chk({tag, "/sb_nonempty"}, (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
         e       = sb.pop_front();
         last    = e;
         rdy_exp = 4'b0001 << e.src;
         chk({tag, "/src"}, bus_if.bus_src, e.src);
         chk({tag, "/op"}, bus_if.bus_op, e.op);
         chk({tag, "/addr"}, bus_if.bus_addr, e.addr);
         chk({tag, "/ready"}, bus_if.req_ready, rdy_exp);
         chk({tag, "/busy"}, bus_if.busy, 1'b1);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "/req_ready"}, bus_if.req_ready, 4'b0000);
      chk({tag, "/bus_valid"}, bus_if.bus_valid, 1'b0);
      chk({tag, "/bus_op"}, bus_if.bus_op, 2'b00);
      chk({tag, "/bus_addr"}, bus_if.bus_addr, 32'h0);
      chk({tag, "/bus_src"}, bus_if.bus_src, 2'd0);
      chk({tag, "/busy"}, bus_if.busy, 1'b0);
      chk({tag, "/timeout_err"}, bus_if.timeout_err, 1'b0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus_if.req_valid = '0;
      bus_if.req_op    = '0;
      bus_if.req_addr  = '0;
      bus_if.bus_done  = 1'b0;

      // Reset values
      repeat (2) tick();
      chk_all_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single request, core 2, done three cycles after ISSUE
      set_req(2, 2'b01, 32'h0000_1040);
      push(2, 2'b01, 32'h0000_1040);
      expect_grant("single", 1);
      clr_req(2);
      tick();
      chk("single/valid_pulse", bus_if.bus_valid, 1'b0);
      chk("single/ready_pulse", bus_if.req_ready, 4'b0000);
      chk("single/addr_hold", bus_if.bus_addr, 32'h0000_1040);
      tick();
      chk("single/busy_c3", bus_if.busy, 1'b1);
      tick();
      bus_if.bus_done = 1'b1;
      chk("single/busy_c4", bus_if.busy, 1'b1);
      tick();
      bus_if.bus_done = 1'b0;
      chk("single/busy_c5", bus_if.busy, 1'b0);

      // Fresh pointer, then all four cores requesting with done in every ISSUE
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) set_req(c, 2'(c), 32'h100 * (c + 1));
      bus_if.bus_done = 1'b1;
      push(0, 2'd0, 32'h100);
      push(1, 2'd1, 32'h200);
      push(2, 2'd2, 32'h300);
      push(3, 2'd3, 32'h400);
      push(0, 2'd0, 32'h100);
      expect_grant("rr0", 1);
      expect_grant("rr1", 2);
      expect_grant("rr2", 2);
      expect_grant("rr3", 2);
      expect_grant("rr4", 2);
      bus_if.req_valid = '0;
      tick();
      bus_if.bus_done = 1'b0;
      chk("rr/idle_after", bus_if.busy, 1'b0);

      // Fairness: after core 2, cores 1 and 3 compete
      set_req(2, 2'b11, 32'h0000_2200);
      push(2, 2'b11, 32'h0000_2200);
      expect_grant("fair_g2", 1);
      clr_req(2);
      bus_if.bus_done = 1'b1;
      tick();
      bus_if.bus_done = 1'b0;
      set_req(1, 2'b00, 32'h0000_1100);
      set_req(3, 2'b10, 32'h0000_3300);
      push(3, 2'b10, 32'h0000_3300);
      push(1, 2'b00, 32'h0000_1100);
      expect_grant("fair_g3", 1);
      clr_req(3);
      bus_if.bus_done = 1'b1;
      expect_grant("fair_g1", 2);
      clr_req(1);
      tick();
      bus_if.bus_done = 1'b0;
      chk("fair/idle_after", bus_if.busy, 1'b0);

      // bus_done in IDLE ignored; in ISSUE it skips WAIT
      bus_if.bus_done = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("idle_done/busy", bus_if.busy, 1'b0);
         chk("idle_done/valid", bus_if.bus_valid, 1'b0);
         chk("idle_done/err", bus_if.timeout_err, 1'b0);
      end
      set_req(0, 2'b00, 32'h0000_0080);
      push(0, 2'b00, 32'h0000_0080);
      expect_grant("done_iss", 1);
      clr_req(0);
      tick();
      chk("done_iss/no_wait", bus_if.busy, 1'b0);
      bus_if.bus_done = 1'b0;

      // bus_done on the cycle the watchdog hits its limit wins
      set_req(1, 2'b10, 32'h000D_EAD0);
      push(1, 2'b10, 32'h000D_EAD0);
      expect_grant("wd_edge", 1);
      clr_req(1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("wd_edge/busy", bus_if.busy, 1'b1);
      end
      tick();
      bus_if.bus_done = 1'b1;
      chk("wd_edge/busy_last", bus_if.busy, 1'b1);
      tick();
      bus_if.bus_done = 1'b0;
      chk("wd_edge/idle", bus_if.busy, 1'b0);
      chk("wd_edge/no_err", bus_if.timeout_err, 1'b0);

      // Hung transaction: error and IDLE nine cycles after ISSUE
      set_req(1, 2'b11, 32'hCAFE_0040);
      push(1, 2'b11, 32'hCAFE_0040);
      expect_grant("wd_hang", 1);
      clr_req(1);
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("wd_hang/busy", bus_if.busy, 1'b1);
         chk("wd_hang/err_low", bus_if.timeout_err, 1'b0);
         chk("wd_hang/addr_hold", bus_if.bus_addr, last.addr);
      end
      tick();
      chk("wd_hang/busy_fall", bus_if.busy, 1'b0);
      chk("wd_hang/err_rise", bus_if.timeout_err, 1'b1);

      set_req(0, 2'b01, 32'h0000_7000);
      push(0, 2'b01, 32'h0000_7000);
      expect_grant("wd_after", 1);
      clr_req(0);
      bus_if.bus_done = 1'b1;
      tick();
      bus_if.bus_done = 1'b0;
      chk("wd_after/idle", bus_if.busy, 1'b0);
      chk("wd_after/err_sticky", bus_if.timeout_err, 1'b1);

      // Reset in WAIT, then pointer back at core 0
      set_req(2, 2'b01, 32'h0000_5500);
      push(2, 2'b01, 32'h0000_5500);
      expect_grant("rst_g2", 1);
      clr_req(2);
      tick();
      chk("rst/in_wait", bus_if.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("rst_async");
      tick();
      rst_n = 1'b1;
      set_req(1, 2'b10, 32'h1111_0000);
      set_req(3, 2'b11, 32'h3333_0000);
      push(1, 2'b10, 32'h1111_0000);
      expect_grant("rst_rr", 1);
      bus_if.req_valid = '0;
      bus_if.bus_done  = 1'b1;
      tick();
      bus_if.bus_done  = 1'b0;
      chk("rst_rr/idle", bus_if.busy, 1'b0);
      chk("sb/drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/moesi_snoop_arbiter.md
# moesi_snoop_arbiter

Round-robin arbiter that sits directly upstream of the shared snoop bus inside `moesi_top`. It takes coherence bus requests from the four per-core MOESI cache controllers (BusRd, BusRdX, BusUpgr, WriteBack) and grants exactly one at a time. It broadcasts the winning transaction on the snoop bus and holds ownership until the bus signals completion. A watchdog flags a hung transaction.

## Interface
- `NUM_CORES`, 4, number of requesting cache controllers (2..8)
- `ADDR_W`, 32, block address width
- `TIMEOUT`, 255, max cycles in WAIT before abort (1..65535)
- `SRC_W`, $clog2(NUM_CORES), width of source id (derived, not overridden)

- `clk`  in  1  system clock; all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  NUM_CORES  per-core request pending
- `req_op`  in  2*NUM_CORES  per-core op: 00 BusRd, 01 BusRdX, 10 BusUpgr, 11 WriteBack
- `req_addr`  in  ADDR_W*NUM_CORES  per-core block address
- `req_ready`  out  NUM_CORES  one-cycle accept pulse to the granted core
- `bus_valid`  out  1  one-cycle broadcast strobe for a new transaction
- `bus_op`  out  2  op of current transaction
- `bus_addr`  out  ADDR_W  address of current transaction
- `bus_src`  out  SRC_W  index of owning core
- `bus_done`  in  1  snoop/data phase of current transaction complete
- `busy`  out  1  transaction in flight (state != IDLE)
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE, any `req_valid` set:
  - Pick the first set bit starting at priority pointer `ptr` and wrapping modulo NUM_CORES.
  - Register op, addr and source into `bus_*`.
  - Set `req_ready[g]` for the next cycle.
  - Set `ptr <= (g+1) mod NUM_CORES`.
  - Go to ISSUE.
- IDLE, no request: stay; outputs hold their last values, `bus_valid`=0.
- ISSUE, lasts exactly one cycle:
  - `bus_valid`=1 and `req_ready[g]`=1.
  - If `bus_done`=1 in this cycle, go to IDLE; else go to WAIT.
- WAIT:
  - `bus_valid`=0; `bus_op`/`bus_addr`/`bus_src` held stable.
  - Watchdog counter increments each cycle.
  - `bus_done`=1: go to IDLE, counter cleared.
  - Counter reaches TIMEOUT without `bus_done`: set `timeout_err`, clear counter, go to IDLE.
- `req_valid` and `req_op`/`req_addr` are ignored outside IDLE.
  - Requesters hold valid/op/addr stable until they see `req_ready`.
  - The granted core drops or replaces its request the cycle after `req_ready`.
- `bus_done` in IDLE is ignored.
- `timeout_err` clears only on reset.
- `busy`: 1 in ISSUE and WAIT, 0 in IDLE (registered with state).

## Timing
- Reset values: state IDLE, `ptr`=0, watchdog counter 0. All outputs 0: `req_ready`, `bus_valid`, `bus_op`, `bus_addr`, `bus_src`, `busy`, `timeout_err`.
- Grant latency: `req_valid` sampled in IDLE cycle T gives `bus_valid`/`req_ready` high in cycle T+1.
- Minimum spacing of `bus_valid` pulses: 2 cycles, achieved when `bus_done` is asserted in the ISSUE cycle.
- `bus_done` in WAIT cycle T puts state in IDLE at T+1; the next `bus_valid` can occur at T+2.
- Timeout: `bus_done` never arrives after ISSUE at cycle T.
  - Counter reaches TIMEOUT in cycle T+TIMEOUT.
  - `timeout_err`=1 and state=IDLE from T+TIMEOUT+1.
- `bus_done` in the same cycle the counter hits TIMEOUT: done wins, no error.
- Reset asserted mid-ISSUE/WAIT: immediate return to reset values. The pending request is not re-granted until requested again after reset.
- `ptr` wraps from NUM_CORES-1 to 0.

## Test plan
- Single request, core 2 (op 01, addr 0x0000_1040), `bus_done` 3 cycles after ISSUE:
  - `bus_valid` pulse one cycle after request with `bus_src`=2, `bus_op`=01, `bus_addr`=0x1040.
  - `req_ready`=4'b0100 in the same cycle.
  - `busy` high for 4 cycles.
- All four cores requesting continuously, `bus_done` in every ISSUE cycle:
  - Grant order 0,1,2,3,0.
  - `bus_valid` every 2 cycles.
- Fairness: after a grant to core 2, cores 1 and 3 request.
  - Core 3 is granted first, then core 1.
- Watchdog, TIMEOUT=8, no `bus_done`:
  - `timeout_err` rises 9 cycles after ISSUE and `busy` falls together with it.
  - Next request is granted normally; `timeout_err` stays 1.
- Reset asserted in WAIT:
  - All outputs 0 immediately and `ptr`=0.
  - After release, simultaneous requests from cores 1 and 3 grant core 1.
- `bus_done` asserted in IDLE and in the ISSUE cycle:
  - Ignored in IDLE.
  - In ISSUE it returns the FSM to IDLE the next cycle, with no WAIT cycle.
